// File: rtl/balance_pipe_seq.sv
// balance_pipe_seq: sequencer between the PID stage (stage 1) and SegwayMath (stage 2).
// It issues one inertial sample at a time to PID and waits out the PID latency.
// It then publishes the PID result, together with the steering context of the same sample, to stage 2.
// One sample that arrives while a sample is in flight is kept in a skid slot.
// Samples lost by overwriting that slot are counted.
module balance_pipe_seq #(
    parameter int S1_LAT = 1,
    parameter int OVR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_in,
    input  logic [15:0]             ptch_in,
    input  logic [15:0]             ptch_rt_in,
    input  logic                    pwr_up_in,
    input  logic                    rider_off_in,
    input  logic [11:0]             steer_pot_in,
    input  logic                    en_steer_in,
    output logic                    vld_s1,
    output logic [15:0]             ptch_s1,
    output logic [15:0]             ptch_rt_s1,
    output logic                    pwr_up_s1,
    output logic                    rider_off_s1,
    input  logic signed [11:0]      PID_cntrl_stage1,
    input  logic [7:0]              ss_tmr_stage1,
    output logic signed [11:0]      PID_cntrl_pipe2,
    output logic [7:0]              ss_tmr_pipe2,
    output logic [11:0]             steer_pot_pipe2,
    output logic                    en_steer_pipe2,
    output logic                    pwr_up_pipe2,
    output logic                    spd_vld,
    output logic                    busy,
    output logic [OVR_W-1:0]        ovr_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUBLISH} state_t;

    state_t                 r_state;
    logic [3:0]             r_wait_cnt;

    // Stage-1 sample and the context captured with it
    logic [15:0]            r_ptch_p1;
    logic [15:0]            r_ptch_rt_p1;
    logic                   r_pwr_up_p1;
    logic                   r_rider_off_p1;
    logic [11:0]            r_steer_p1;
    logic                   r_en_steer_p1;

    // Skid slot: holds the most recent sample seen while busy
    logic                   r_slot_full;
    logic [15:0]            r_slot_ptch;
    logic [15:0]            r_slot_ptch_rt;
    logic                   r_slot_pwr_up;
    logic                   r_slot_rider_off;
    logic [11:0]            r_slot_steer;
    logic                   r_slot_en_steer;

    // Stage-2 registers
    logic signed [11:0]     r_pid_p2;
    logic [7:0]             r_ss_tmr_p2;
    logic [11:0]            r_steer_p2;
    logic                   r_en_steer_p2;
    logic                   r_pwr_up_p2;

    logic [OVR_W-1:0]       r_ovr_cnt;

    logic                   w_capture;
    logic                   w_drop;

    // A new sample starts from IDLE or back-to-back from PUBLISH
    assign w_capture = ((r_state == IDLE) || (r_state == PUBLISH)) && (vld_in || r_slot_full);
    // A full slot plus a new arrival always costs one sample, whichever state we are in
    assign w_drop    = vld_in && r_slot_full;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (&v) ? v : v + {{(OVR_W-1){1'b0}}, 1'b1};
    endfunction

    // Sequencer FSM with the sample, skid-slot, stage-2 and overrun registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_wait_cnt       <= '0;
            r_ptch_p1        <= '0;
            r_ptch_rt_p1     <= '0;
            r_pwr_up_p1      <= 1'b0;
            r_rider_off_p1   <= 1'b0;
            r_steer_p1       <= '0;
            r_en_steer_p1    <= 1'b0;
            r_slot_full      <= 1'b0;
            r_slot_ptch      <= '0;
            r_slot_ptch_rt   <= '0;
            r_slot_pwr_up    <= 1'b0;
            r_slot_rider_off <= 1'b0;
            r_slot_steer     <= '0;
            r_slot_en_steer  <= 1'b0;
            r_pid_p2         <= '0;
            r_ss_tmr_p2      <= '0;
            r_steer_p2       <= '0;
            r_en_steer_p2    <= 1'b0;
            r_pwr_up_p2      <= 1'b0;
            r_ovr_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE, PUBLISH: begin
                    if (w_capture) begin
                        // a live sample takes priority over the one waiting in the slot
                        if (vld_in) begin
                            r_ptch_p1      <= ptch_in;
                            r_ptch_rt_p1   <= ptch_rt_in;
                            r_pwr_up_p1    <= pwr_up_in;
                            r_rider_off_p1 <= rider_off_in;
                            r_steer_p1     <= steer_pot_in;
                            r_en_steer_p1  <= en_steer_in;
                        end else begin
                            r_ptch_p1      <= r_slot_ptch;
                            r_ptch_rt_p1   <= r_slot_ptch_rt;
                            r_pwr_up_p1    <= r_slot_pwr_up;
                            r_rider_off_p1 <= r_slot_rider_off;
                            r_steer_p1     <= r_slot_steer;
                            r_en_steer_p1  <= r_slot_en_steer;
                        end
                        r_slot_full <= 1'b0;
                        r_state     <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= 4'(S1_LAT);
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt <= 4'd1) begin
                        r_pid_p2      <= PID_cntrl_stage1;
                        r_ss_tmr_p2   <= ss_tmr_stage1;
                        r_steer_p2    <= r_steer_p1;
                        r_en_steer_p2 <= r_en_steer_p1;
                        r_pwr_up_p2   <= r_pwr_up_p1;
                        r_state       <= PUBLISH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // While a sample is in flight the newest arrival parks in the slot
            if (vld_in && ((r_state == ISSUE) || (r_state == WAIT))) begin
                r_slot_full      <= 1'b1;
                r_slot_ptch      <= ptch_in;
                r_slot_ptch_rt   <= ptch_rt_in;
                r_slot_pwr_up    <= pwr_up_in;
                r_slot_rider_off <= rider_off_in;
                r_slot_steer     <= steer_pot_in;
                r_slot_en_steer  <= en_steer_in;
            end

            if (w_drop) begin
                r_ovr_cnt <= sat_inc(r_ovr_cnt);
            end

            // Fast power-down of stage 2 wins over a coincident load
            if (!pwr_up_in) begin
                r_pwr_up_p2 <= 1'b0;
                r_pid_p2    <= '0;
            end
        end
    end

    assign vld_s1          = (r_state == ISSUE);
    assign spd_vld         = (r_state == PUBLISH);
    assign busy            = (r_state != IDLE);
    assign ptch_s1         = r_ptch_p1;
    assign ptch_rt_s1      = r_ptch_rt_p1;
    assign pwr_up_s1       = r_pwr_up_p1;
    assign rider_off_s1    = r_rider_off_p1;
    assign PID_cntrl_pipe2 = r_pid_p2;
    assign ss_tmr_pipe2    = r_ss_tmr_p2;
    assign steer_pot_pipe2 = r_steer_p2;
    assign en_steer_pipe2  = r_en_steer_p2;
    assign pwr_up_pipe2    = r_pwr_up_p2;
    assign ovr_cnt         = r_ovr_cnt;

endmodule

// File: tb/tb_balance_pipe_seq.sv
// Directed bench for balance_pipe_seq: one instance with S1_LAT=1 (a_*) and one with S1_LAT=4 (b_*), shared stimulus.
module tb_balance_pipe_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic [15:0] ptch_in;
    logic [15:0] ptch_rt_in;
    logic        pwr_up_in;
    logic        rider_off_in;
    logic [11:0] steer_pot_in;
    logic        en_steer_in;
    logic [11:0] pid_in;
    logic [7:0]  ss_in;

    logic        a_vld_s1, a_pwr_up_s1, a_rider_off_s1, a_en_p2, a_pwr_p2, a_spd_vld, a_busy;
    logic [15:0] a_ptch_s1, a_ptch_rt_s1;
    logic [11:0] a_pid_p2, a_steer_p2;
    logic [7:0]  a_ss_p2, a_ovr;

    logic        b_vld_s1, b_pwr_up_s1, b_rider_off_s1, b_en_p2, b_pwr_p2, b_spd_vld, b_busy;
    logic [15:0] b_ptch_s1, b_ptch_rt_s1;
    logic [11:0] b_pid_p2, b_steer_p2;
    logic [7:0]  b_ss_p2, b_ovr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    balance_pipe_seq #(.S1_LAT(1), .OVR_W(8)) dut_a (
        .clk(clk), .rst(rst), .vld_in(vld_in), .ptch_in(ptch_in), .ptch_rt_in(ptch_rt_in),
        .pwr_up_in(pwr_up_in), .rider_off_in(rider_off_in), .steer_pot_in(steer_pot_in),
        .en_steer_in(en_steer_in), .vld_s1(a_vld_s1), .ptch_s1(a_ptch_s1), .ptch_rt_s1(a_ptch_rt_s1),
        .pwr_up_s1(a_pwr_up_s1), .rider_off_s1(a_rider_off_s1), .PID_cntrl_stage1(pid_in),
        .ss_tmr_stage1(ss_in), .PID_cntrl_pipe2(a_pid_p2), .ss_tmr_pipe2(a_ss_p2),
        .steer_pot_pipe2(a_steer_p2), .en_steer_pipe2(a_en_p2), .pwr_up_pipe2(a_pwr_p2),
        .spd_vld(a_spd_vld), .busy(a_busy), .ovr_cnt(a_ovr)
    );

    balance_pipe_seq #(.S1_LAT(4), .OVR_W(8)) dut_b (
        .clk(clk), .rst(rst), .vld_in(vld_in), .ptch_in(ptch_in), .ptch_rt_in(ptch_rt_in),
        .pwr_up_in(pwr_up_in), .rider_off_in(rider_off_in), .steer_pot_in(steer_pot_in),
        .en_steer_in(en_steer_in), .vld_s1(b_vld_s1), .ptch_s1(b_ptch_s1), .ptch_rt_s1(b_ptch_rt_s1),
        .pwr_up_s1(b_pwr_up_s1), .rider_off_s1(b_rider_off_s1), .PID_cntrl_stage1(pid_in),
        .ss_tmr_stage1(ss_in), .PID_cntrl_pipe2(b_pid_p2), .ss_tmr_pipe2(b_ss_p2),
        .steer_pot_pipe2(b_steer_p2), .en_steer_pipe2(b_en_p2), .pwr_up_pipe2(b_pwr_p2),
        .spd_vld(b_spd_vld), .busy(b_busy), .ovr_cnt(b_ovr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [15:0] p, input logic [11:0] st);
        vld_in       = 1'b1;
        ptch_in      = p;
        ptch_rt_in   = p + 16'h0001;
        steer_pot_in = st;
    endtask

    initial begin
        rst = 1'b1; vld_in = 1'b0; ptch_in = '0; ptch_rt_in = '0; pwr_up_in = 1'b1;
        rider_off_in = 1'b0; steer_pot_in = '0; en_steer_in = 1'b1; pid_in = '0; ss_in = 8'h55;
        tick();
        rst = 1'b0;
        chk("rst_busy", a_busy, 0);
        chk("rst_ovr", a_ovr, 0);
        chk("rst_vld_s1", a_vld_s1, 0);
        chk("rst_spd_vld", a_spd_vld, 0);
        chk("rst_pwr_p2", a_pwr_p2, 0);
        chk("rst_ptch_s1", a_ptch_s1, 0);

        // single sample, latency for S1_LAT=1 and S1_LAT=4
        sample(16'h0100, 12'h123); pid_in = 12'hF80;
        tick();                                   // N+1
        vld_in = 1'b0;
        chk("t1_vld_s1", a_vld_s1, 1);
        chk("t1_ptch_s1", a_ptch_s1, 16'h0100);
        chk("t1_ptch_rt_s1", a_ptch_rt_s1, 16'h0101);
        chk("t1_pwr_s1", a_pwr_up_s1, 1);
        chk("t1_busy", a_busy, 1);
        chk("t1b_vld_s1", b_vld_s1, 1);
        tick();                                   // N+2
        chk("t1_spd_early", a_spd_vld, 0);
        tick();                                   // N+3
        chk("t1_spd_vld", a_spd_vld, 1);
        chk("t1_pid_p2", a_pid_p2, 12'hF80);
        chk("t1_ss_p2", a_ss_p2, 8'h55);
        chk("t1_steer_p2", a_steer_p2, 12'h123);
        chk("t1_en_p2", a_en_p2, 1);
        chk("t1_pwr_p2", a_pwr_p2, 1);
        tick();                                   // N+4
        chk("t1_idle", a_busy, 0);
        chk("t1_spd_once", a_spd_vld, 0);
        tick();                                   // N+5
        chk("t1b_spd_early", b_spd_vld, 0);
        tick();                                   // N+6
        chk("t1b_spd_vld", b_spd_vld, 1);
        chk("t1b_pid_p2", b_pid_p2, 12'hF80);
        tick();
        tick();
        chk("t1b_idle", b_busy, 0);

        // back-to-back pair: second sample waits in the slot
        sample(16'h0200, 12'h200); pid_in = 12'h111;
        tick();                                   // N+1
        sample(16'h0300, 12'h300);
        chk("t2_vld_s1", a_vld_s1, 1);
        chk("t2_ptch_s1_a", a_ptch_s1, 16'h0200);
        tick();                                   // N+2
        vld_in = 1'b0;
        chk("t2_s1_hold", a_ptch_s1, 16'h0200);
        tick();                                   // N+3
        pid_in = 12'h222;
        chk("t2_spd1", a_spd_vld, 1);
        chk("t2_pid1", a_pid_p2, 12'h111);
        chk("t2_steer1", a_steer_p2, 12'h200);
        tick();                                   // N+4
        chk("t2_issue2", a_vld_s1, 1);
        chk("t2_ptch_s1_b", a_ptch_s1, 16'h0300);
        tick();                                   // N+5
        chk("t2_spd_gap", a_spd_vld, 0);
        tick();                                   // N+6
        chk("t2_spd2", a_spd_vld, 1);
        chk("t2_pid2", a_pid_p2, 12'h222);
        chk("t2_steer2", a_steer_p2, 12'h300);
        chk("t2_ovr", a_ovr, 0);
        tick();
        chk("t2_idle", a_busy, 0);
        repeat (8) tick();                        // let dut_b drain its slot

        // three in a row: middle sample is overwritten
        sample(16'h0400, 12'h400);
        tick();                                   // N+1
        sample(16'h0500, 12'h500);
        tick();                                   // N+2
        sample(16'h0600, 12'h600);
        tick();                                   // N+3
        vld_in = 1'b0;
        chk("t3_spd1", a_spd_vld, 1);
        chk("t3_ovr", a_ovr, 1);
        tick();                                   // N+4
        chk("t3_issue3", a_vld_s1, 1);
        chk("t3_ptch3", a_ptch_s1, 16'h0600);
        tick();
        tick();                                   // N+6
        chk("t3_spd3", a_spd_vld, 1);
        chk("t3_steer3", a_steer_p2, 12'h600);
        tick();
        tick();
        chk("t3_idle", a_busy, 0);
        chk("t3_ovr_hold", a_ovr, 1);
        repeat (12) tick();

        // power-down during WAIT overrides the publish load
        sample(16'h0700, 12'h700); pid_in = 12'h333;
        tick();                                   // N+1 ISSUE
        vld_in = 1'b0;
        tick();                                   // N+2 WAIT
        pwr_up_in = 1'b0;
        tick();                                   // N+3 PUBLISH
        pwr_up_in = 1'b1;
        chk("t5_spd", a_spd_vld, 1);
        chk("t5_pwr_p2", a_pwr_p2, 0);
        chk("t5_pid_p2", a_pid_p2, 0);
        tick();                                   // N+4
        chk("t5_pwr_stays", a_pwr_p2, 0);
        sample(16'h0800, 12'h080); pid_in = 12'h7FF;
        tick();
        vld_in = 1'b0;
        tick();
        tick();
        chk("t5_repub_spd", a_spd_vld, 1);
        chk("t5_repub_pwr", a_pwr_p2, 1);
        chk("t5_repub_pid", a_pid_p2, 12'h7FF);
        repeat (8) tick();

        // continuous arrivals: overrun counter saturates
        vld_in = 1'b1;
        for (int i = 0; i < 450; i++) begin
            ptch_in = 16'(i);
            tick();
        end
        chk("t4_sat_a", a_ovr, 8'hFF);
        chk("t4_sat_b", b_ovr, 8'hFF);
        repeat (30) tick();
        chk("t4_nowrap", a_ovr, 8'hFF);
        vld_in = 1'b0;
        repeat (10) tick();

        // reset during WAIT with the slot full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ovr_clr", a_ovr, 0);
        sample(16'h0900, 12'h900);
        tick();                                   // N+1 ISSUE
        sample(16'h0A00, 12'hA00);
        tick();                                   // N+2 WAIT, slot full
        vld_in = 1'b0;
        tick();                                   // N+3 WAIT
        rst = 1'b1;
        tick();                                   // N+4
        rst = 1'b0;
        chk("t6_busy", b_busy, 0);
        chk("t6_spd", b_spd_vld, 0);
        chk("t6_ovr", b_ovr, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_slot_empty", b_busy, 0);
        end
        sample(16'h0B00, 12'hB00); pid_in = 12'h456;
        tick();                                   // M+1
        vld_in = 1'b0;
        chk("t6_vld_s1", b_vld_s1, 1);
        repeat (4) tick();                        // M+5
        chk("t6_spd_early", b_spd_vld, 0);
        tick();                                   // M+6
        chk("t6_spd_vld", b_spd_vld, 1);
        chk("t6_pid_p2", b_pid_p2, 12'h456);
        chk("t6_steer_p2", b_steer_p2, 12'hB00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
